// File: rtl/pe_psum_accumulator.sv
// Partial-sum accumulator placed behind the 16-brick PE.
// Sums a programmable number of signed products into one partial sum, then
// applies a rounding right shift, optional ReLU and signed saturation. The
// result sits in a single-entry output register. While that entry is held,
// the product stream is backpressured.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for the first product of a group
//   S_ACCUM | group partially accumulated, r_rem products still to come
//   S_HOLD  | result registered on o_psum, waiting for i_psum_ready
module pe_psum_accumulator #(
  parameter int PROD_W = 13,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clear,
  input  logic [7:0]               i_len,
  input  logic [3:0]               i_out_shift,
  input  logic                     i_relu,
  input  logic                     i_prod_valid,
  input  logic signed [PROD_W-1:0] i_prod,
  output logic                     o_prod_ready,
  output logic                     o_psum_valid,
  output logic signed [OUT_W-1:0]  o_psum,
  output logic                     o_sat,
  input  logic                     i_psum_ready
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  localparam int                   OUT_MAX_I = (2 ** (OUT_W - 1)) - 1;
  localparam logic signed [ACC_W:0] SAT_MAX  = (ACC_W + 1)'(OUT_MAX_I);
  localparam logic signed [ACC_W:0] SAT_MIN  = (ACC_W + 1)'(-OUT_MAX_I - 1);
  localparam logic signed [ACC_W:0] RND_ONE  = (ACC_W + 1)'(1);

  state_t                  r_state, w_state_nxt;
  logic signed [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [7:0]              r_rem, w_rem_nxt;
  logic [3:0]              r_shift, w_shift_nxt;
  logic                    r_relu, w_relu_nxt;
  logic                    r_valid, w_valid_nxt;
  logic signed [OUT_W-1:0] r_psum, w_psum_nxt;
  logic                    r_sat, w_sat_nxt;

  logic signed [ACC_W-1:0] w_prod_ext;
  logic                    w_accept;
  logic                    w_start;
  logic                    w_last;
  logic signed [ACC_W-1:0] w_fin_acc;
  logic [3:0]              w_fin_shift;
  logic                    w_fin_relu;

  logic signed [ACC_W:0]   w_ext, w_rnd, w_sum, w_shr, w_clip;
  logic signed [OUT_W-1:0] w_rq_psum;
  logic                    w_rq_sat;

  // Handshake and group bookkeeping. A product accepted outside S_ACCUM always opens a new group.
  always_comb begin
    o_prod_ready = (r_state != S_HOLD) || i_psum_ready;
    w_prod_ext   = {{(ACC_W - PROD_W){i_prod[PROD_W-1]}}, i_prod};
    w_accept     = i_prod_valid && o_prod_ready && !i_clear;
    w_start      = w_accept && (r_state != S_ACCUM);
    w_last       = w_start ? (i_len == 8'd1) : (r_rem == 8'd1);
    if (r_state == S_ACCUM) begin
      w_fin_acc   = r_acc + w_prod_ext;
      w_fin_shift = r_shift;
      w_fin_relu  = r_relu;
    end else begin
      w_fin_acc   = w_prod_ext;
      w_fin_shift = i_out_shift;
      w_fin_relu  = i_relu;
    end
  end

  // Requantise the would-be final sum: rounding shift at ACC_W+1 bits, then ReLU, then saturate.
  always_comb begin
    w_ext = {w_fin_acc[ACC_W-1], w_fin_acc};
    w_rnd = '0;
    if (w_fin_shift != 4'd0) begin
      w_rnd = RND_ONE << (w_fin_shift - 4'd1);
    end
    w_sum  = w_ext + w_rnd;
    w_shr  = w_sum >>> w_fin_shift;
    w_clip = w_shr;
    if (w_fin_relu && w_shr[ACC_W]) begin
      w_clip = '0;
    end
    w_rq_sat  = 1'b0;
    w_rq_psum = w_clip[OUT_W-1:0];
    if (w_clip > SAT_MAX) begin
      w_rq_psum = SAT_MAX[OUT_W-1:0];
      w_rq_sat  = 1'b1;
    end else if (w_clip < SAT_MIN) begin
      w_rq_psum = SAT_MIN[OUT_W-1:0];
      w_rq_sat  = 1'b1;
    end
  end

  // Next-state and datapath updates. Clear wins. Then consume the held result, then apply any accept.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_rem_nxt   = r_rem;
    w_shift_nxt = r_shift;
    w_relu_nxt  = r_relu;
    w_valid_nxt = r_valid;
    w_psum_nxt  = r_psum;
    w_sat_nxt   = r_sat;
    if (i_clear) begin
      w_state_nxt = S_IDLE;
      w_acc_nxt   = '0;
      w_rem_nxt   = '0;
      w_valid_nxt = 1'b0;
      w_sat_nxt   = 1'b0;
    end else begin
      if ((r_state == S_HOLD) && i_psum_ready) begin
        w_valid_nxt = 1'b0;
        w_state_nxt = S_IDLE;
      end
      if (w_accept) begin
        w_acc_nxt = w_fin_acc;
        if (w_start) begin
          w_shift_nxt = i_out_shift;
          w_relu_nxt  = i_relu;
          w_rem_nxt   = i_len - 8'd1;
        end else begin
          w_rem_nxt   = r_rem - 8'd1;
        end
        if (w_last) begin
          w_psum_nxt  = w_rq_psum;
          w_sat_nxt   = w_rq_sat;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_HOLD;
        end else begin
          w_state_nxt = S_ACCUM;
        end
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_rem   <= '0;
      r_shift <= '0;
      r_relu  <= 1'b0;
      r_valid <= 1'b0;
      r_psum  <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_rem   <= w_rem_nxt;
      r_shift <= w_shift_nxt;
      r_relu  <= w_relu_nxt;
      r_valid <= w_valid_nxt;
      r_psum  <= w_psum_nxt;
      r_sat   <= w_sat_nxt;
    end
  end

  assign o_psum_valid = r_valid;
  assign o_psum       = r_psum;
  assign o_sat        = r_sat;

endmodule

// File: tb/tb_pe_psum_accumulator.sv
// Directed bench for pe_psum_accumulator with an integer-level reference model.
module tb_pe_psum_accumulator;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_clear = 1'b0;
  logic [7:0]        i_len = 8'd0;
  logic [3:0]        i_out_shift = 4'd0;
  logic              i_relu = 1'b0;
  logic              i_prod_valid = 1'b0;
  logic signed [12:0] i_prod = '0;
  logic              i_psum_ready = 1'b1;
  wire               o_prod_ready;
  wire               o_psum_valid;
  wire signed [15:0] o_psum;
  wire               o_sat;

  pe_psum_accumulator #(.PROD_W(13), .ACC_W(24), .OUT_W(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear), .i_len(i_len),
    .i_out_shift(i_out_shift), .i_relu(i_relu), .i_prod_valid(i_prod_valid),
    .i_prod(i_prod), .o_prod_ready(o_prod_ready), .o_psum_valid(o_psum_valid),
    .o_psum(o_psum), .o_sat(o_sat), .i_psum_ready(i_psum_ready)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;
  int got_q[$];
  int sat_q[$];
  int n_valid = 0;

  typedef struct {
    bit     valid;
    int     psum;
    bit     sat;
    int     got;
    int     len;
    int     sh;
    bit     relu;
    longint sum;
  } model_t;

  model_t m;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void requant(input longint s, input int sh, input bit relu,
                                  output int p, output bit sat);
    longint r = s;
    if (sh > 0) r = (s + (longint'(1) << (sh - 1))) >>> sh;
    if (relu && r < 0) r = 0;
    sat = 1'b0;
    if (r > 32767) begin r = 32767; sat = 1'b1; end
    else if (r < -32768) begin r = -32768; sat = 1'b1; end
    p = int'(r);
  endfunction

  // One clock of the reference behaviour: results are emitted after len products; a held result blocks input.
  function automatic model_t step(input model_t cur);
    model_t nx = cur;
    bit rdy;
    int p;
    bit s;
    rdy = !cur.valid || i_psum_ready;
    if (i_clear) begin
      nx.valid = 1'b0;
      nx.sat = 1'b0;
      nx.got = 0;
      return nx;
    end
    if (cur.valid && i_psum_ready) nx.valid = 1'b0;
    if (i_prod_valid && rdy) begin
      if (cur.got == 0) begin
        nx.len  = (i_len == 8'd0) ? 256 : int'(i_len);
        nx.sh   = int'(i_out_shift);
        nx.relu = i_relu;
        nx.sum  = longint'(i_prod);
        nx.got  = 1;
      end else begin
        nx.sum = cur.sum + longint'(i_prod);
        nx.got = cur.got + 1;
      end
      if (nx.got == nx.len) begin
        requant(nx.sum, nx.sh, nx.relu, p, s);
        nx.psum  = p;
        nx.sat   = s;
        nx.valid = 1'b1;
        nx.got   = 0;
      end
    end
    return nx;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) m <= '{default: 0};
    else          m <= step(m);
  end

  // Per-cycle comparison against the model, sampled mid-cycle; also logs every handed-off result.
  initial forever begin
    @(negedge i_clk);
    if (i_rst_n) begin
      chk("prod_ready", longint'(o_prod_ready), longint'(!m.valid || i_psum_ready));
      chk("psum_valid", longint'(o_psum_valid), longint'(m.valid));
      if (m.valid) begin
        chk("psum", longint'(o_psum), longint'(m.psum));
        chk("sat", longint'(o_sat), longint'(m.sat));
      end
      if (o_psum_valid) n_valid++;
      if (o_psum_valid && i_psum_ready) begin
        got_q.push_back(int'(o_psum));
        sat_q.push_back(int'(o_sat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push(input int p);
    i_prod_valid = 1'b1;
    i_prod = 13'(p);
    cyc();
  endtask

  task automatic idle(input int n);
    i_prod_valid = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic cfg(input int len, input int sh, input bit relu);
    i_len = 8'(len);
    i_out_shift = 4'(sh);
    i_relu = relu;
  endtask

  task automatic chk_res(input string name, input int idx, input int exp_p, input int exp_s);
    if (idx >= got_q.size()) begin
      checks++;
      failures++;
      $display("FAIL %s: no result at index %0d (have %0d) expected %0d", name, idx, got_q.size(), exp_p);
    end else begin
      chk(name, longint'(got_q[idx]), longint'(exp_p));
      chk({name, "_sat"}, longint'(sat_q[idx]), longint'(exp_s));
    end
  endtask

  initial begin
    int base;
    #1;
    chk("rst_valid", longint'(o_psum_valid), 0);
    chk("rst_psum", longint'(o_psum), 0);
    chk("rst_sat", longint'(o_sat), 0);
    chk("rst_ready", longint'(o_prod_ready), 1);
    cyc();
    cyc();
    i_rst_n = 1'b1;
    cyc();

    // Plain sum of four products, one-cycle result pulse.
    base = got_q.size();
    n_valid = 0;
    cfg(4, 0, 0);
    push(100); push(-20); push(4095); push(-4096);
    idle(3);
    chk("t1_valid_cycles", longint'(n_valid), 1);
    chk_res("t1_psum", base, 79, 0);

    // len=1 streaming: one result per cycle.
    base = got_q.size();
    cfg(1, 0, 0);
    push(5); push(6); push(7);
    idle(2);
    chk("t2_count", longint'(got_q.size() - base), 3);
    chk_res("t2_a", base, 5, 0);
    chk_res("t2_b", base + 1, 6, 0);
    chk_res("t2_c", base + 2, 7, 0);

    // Backpressure while the result is held; pending product enters on release.
    base = got_q.size();
    cfg(2, 0, 0);
    i_psum_ready = 1'b0;
    push(10); push(20);
    i_prod_valid = 1'b1;
    i_prod = 13'(99);
    repeat (5) cyc();
    chk("t3_ready_low", longint'(o_prod_ready), 0);
    chk("t3_held_psum", longint'(o_psum), 30);
    i_psum_ready = 1'b1;
    cyc();
    push(1);
    idle(2);
    chk_res("t3_first", base, 30, 0);
    chk_res("t3_second", base + 1, 100, 0);

    // Rounding shift and ReLU.
    base = got_q.size();
    cfg(2, 3, 0);
    push(13); push(0);
    push(-13); push(0);
    cfg(2, 3, 1);
    push(-13); push(0);
    idle(2);
    chk_res("t4_pos", base, 2, 0);
    chk_res("t4_neg", base + 1, -2, 0);
    chk_res("t4_relu", base + 2, 0, 0);

    // len=0 means 256 products; saturation both ways.
    base = got_q.size();
    cfg(0, 0, 0);
    for (int k = 0; k < 256; k++) push(4095);
    for (int k = 0; k < 256; k++) push(-4096);
    idle(2);
    chk_res("t5_pos_sat", base, 32767, 1);
    chk_res("t5_neg_sat", base + 1, -32768, 1);

    // Clear mid-group drops the group and the product presented with it.
    base = got_q.size();
    cfg(4, 0, 0);
    push(1); push(1);
    i_clear = 1'b1;
    push(7);
    i_clear = 1'b0;
    push(1); push(1); push(1); push(1);
    idle(2);
    chk("t6_count", longint'(got_q.size() - base), 1);
    chk_res("t6_psum", base, 4, 0);

    // Async reset while a result is held.
    i_psum_ready = 1'b0;
    cfg(1, 0, 0);
    push(9);
    idle(1);
    chk("t6_held_valid", longint'(o_psum_valid), 1);
    chk("t6_held_psum", longint'(o_psum), 9);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("t6_arst_valid", longint'(o_psum_valid), 0);
    chk("t6_arst_psum", longint'(o_psum), 0);
    chk("t6_arst_sat", longint'(o_sat), 0);
    cyc();
    i_rst_n = 1'b1;
    i_psum_ready = 1'b1;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_psum_accumulator.md
Name: pe_psum_accumulator

Overview:
Sits directly downstream of the 16-brick PE. It consumes the PE's registered 13-bit signed product stream and accumulates a programmable number of products into one partial sum. It then applies rounding right-shift requantisation, optional ReLU and signed saturation. It presents the result on a valid/ready output with single-entry buffering, and backpressures the product stream while that entry is held.

Parameters:
PROD_W, 13, signed width of incoming PE product
ACC_W, 24, internal accumulator width (holds 256 x full-scale PROD_W products without wrap)
OUT_W, 16, signed width of requantised output

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_clear  in  1  synchronous abort; discards accumulation and any held output
i_len  in  8  products per result; 0 means 256; sampled on first product of a group
i_out_shift  in  4  arithmetic right-shift amount (0..15); sampled on first product
i_relu  in  1  clamp negative results to 0; sampled on first product
i_prod_valid  in  1  product valid
i_prod  in  PROD_W  signed product from PE
o_prod_ready  out  1  block accepts product this cycle
o_psum_valid  out  1  result valid
o_psum  out  OUT_W  signed requantised partial sum
o_sat  out  1  result was saturated (qualifies o_psum)
i_psum_ready  in  1  downstream accepts result

Behaviour:
- Reset (async): state=IDLE; acc=0; counter=0; o_psum_valid=0; o_psum=0; o_sat=0. Latched len, shift and relu are cleared to 0.
- Accept: a product is accepted when i_prod_valid && o_prod_ready.
- o_prod_ready = (state!=HOLD) || i_psum_ready. It is combinational from state and i_psum_ready.
- States:
  - IDLE: waiting for the first product of a group.
  - ACCUM: group partially accumulated.
  - HOLD: result registered, waiting for downstream.
- IDLE + accept:
  - acc = sext(i_prod); latch len/shift/relu; remaining = len-1 (len=0 treated as 256).
  - If remaining==0, finish this cycle; else go to ACCUM.
- ACCUM + accept: acc += sext(i_prod); remaining--. Finish when the accepted product is the last one. Idle cycles (no valid) hold all state.
- Finish (same edge as the last accept):
  - r = (acc_final + (shift? 1<<(shift-1) : 0)) >>> shift, evaluated at ACC_W+1 bits.
  - If relu and r<0, then r=0.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; o_sat=1 iff clamped.
  - Register o_psum/o_sat; o_psum_valid=1; state=HOLD.
  - Latency: o_psum_valid rises the cycle after the last product is accepted.
- HOLD:
  - o_psum/o_sat stay stable while o_psum_valid && !i_psum_ready.
  - On i_psum_ready, the result is consumed.
  - If a product is accepted in that same cycle, it starts a new group: IDLE-accept rules apply, with o_psum_valid updated per that group (stays 1 only if len==1).
  - Otherwise o_psum_valid=0 and state=IDLE.
  - Back-to-back len=1 groups therefore sustain one result per cycle with no bubble.
- i_clear: synchronous, highest priority. Forces state=IDLE, acc=0, o_psum_valid=0, o_sat=0. Any product presented that cycle is dropped, and o_prod_ready is still driven per the formula above.
- Async reset mid-group or mid-HOLD: everything returns to reset values and no result is emitted.
- Arithmetic: two's complement, sign-extended adds. The accumulator never wraps for len<=256 at PROD_W=13.
- Parameter changes (i_len/shift/relu) mid-group have no effect until the next first product.

Test Plan:
1. i_len=4, shift=0, relu=0; products 100,-20,4095,-4096 on consecutive cycles, i_psum_ready=1 -> o_psum=79, o_sat=0, o_psum_valid high exactly one cycle, starting the cycle after the 4th accept.
2. i_len=1, i_psum_ready=1; products 5,6,7 back-to-back -> o_psum 5,6,7 on three consecutive cycles; o_prod_ready never drops.
3. i_len=2; products 10,20; i_psum_ready=0 for 5 cycles -> o_psum=30 stable, o_prod_ready=0, a presented product 99 is not accepted. Then ready=1 -> 99 is accepted that same cycle as the first product of the next group.
4. i_len=2, shift=3; products 13,0 -> o_psum=2. Products -13,0 with relu=0 -> -2. Same with relu=1 -> 0, o_sat=0.
5. i_len=0 (256), shift=0; 256 products of 4095 -> acc=1048320, o_psum=32767, o_sat=1. Same with all -4096 -> o_psum=-32768, o_sat=1.
6. i_len=4; pulse i_clear after 2 accepts -> no result emitted. Then products 1,1,1,1 -> o_psum=4. Also assert i_rst_n low during HOLD -> o_psum_valid=0 and o_psum=0 immediately (asynchronously).
